// File: rtl/k6502_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k6502_pkg
// Brief    : Shared types for the k6502 timing generator: T-state encoding,
//            datapath control bundle and supported opcode values.
// Revision : 1.0 - initial release
// ============================================================================
package k6502_pkg;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3
    } t_state_e;

    typedef struct packed {
        logic ac_sb;
        logic sb_x;
        logic sb_y;
        logic x_sb;
        logic y_sb;
        logic sb_add;
        logic add_sb_6_0;
        logic add_sb_7;
        logic dl_adl;
        logic adl_abl;
        logic dl_adh;
        logic adh_abh;
    } control_signals_t;

    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TAY     = 8'hA8;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    // Reset leaves a NOP in the instruction register.
    localparam logic [7:0] IR_RESET   = OP_NOP;

endpackage : k6502_pkg
`default_nettype wire

// File: rtl/k6502_timing_if.sv
`default_nettype none
// ============================================================================
// Module   : k6502_timing_if
// Brief    : Bus between the timing generator (master) and datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface k6502_timing_if;
    import k6502_pkg::*;

    logic             rdy;
    logic [7:0]       pd;
    control_signals_t ctl;
    logic             pc_inc;
    logic             pc_load;
    logic             sync;
    logic [2:0]       t_state;
    logic [7:0]       ir;
    logic             illegal;

    modport master (
        input  rdy, pd,
        output ctl, pc_inc, pc_load, sync, t_state, ir, illegal
    );

    modport slave (
        output rdy, pd,
        input  ctl, pc_inc, pc_load, sync, t_state, ir, illegal
    );

endinterface : k6502_timing_if
`default_nettype wire

// File: rtl/k6502_decode.sv
`default_nettype none
// ============================================================================
// Module   : k6502_decode
// Brief    : Combinational opcode table: control bits per (ir, T-state).
// Revision : 1.0 - initial release
// ============================================================================
module k6502_decode
    import k6502_pkg::*;
(
    input  wire logic [7:0]       ir,
    input  wire logic [2:0]       t_state,
    output control_signals_t      ctl,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  illegal,
    output logic                  last_cycle
);

    always_comb begin
        ctl        = '0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        illegal    = 1'b0;
        last_cycle = 1'b0;
        case (t_state)
            T0: pc_inc = 1'b1;
            T1: begin
                case (ir)
                    OP_NOP: last_cycle = 1'b1;
                    OP_TAX: begin
                        ctl.ac_sb  = 1'b1;
                        ctl.sb_x   = 1'b1;
                        last_cycle = 1'b1;
                    end
                    OP_TAY: begin
                        ctl.ac_sb  = 1'b1;
                        ctl.sb_y   = 1'b1;
                        last_cycle = 1'b1;
                    end
                    OP_INX: begin
                        ctl.x_sb   = 1'b1;
                        ctl.sb_add = 1'b1;
                    end
                    OP_INY: begin
                        ctl.y_sb   = 1'b1;
                        ctl.sb_add = 1'b1;
                    end
                    OP_JMP_ABS: pc_inc = 1'b1;
                    default: begin
                        // Unsupported opcodes behave as a flagged 2-cycle NOP.
                        illegal    = 1'b1;
                        last_cycle = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (ir)
                    OP_INX: begin
                        ctl.add_sb_6_0 = 1'b1;
                        ctl.add_sb_7   = 1'b1;
                        ctl.sb_x       = 1'b1;
                        last_cycle     = 1'b1;
                    end
                    OP_INY: begin
                        ctl.add_sb_6_0 = 1'b1;
                        ctl.add_sb_7   = 1'b1;
                        ctl.sb_y       = 1'b1;
                        last_cycle     = 1'b1;
                    end
                    OP_JMP_ABS: begin
                        ctl.dl_adl  = 1'b1;
                        ctl.adl_abl = 1'b1;
                        pc_inc      = 1'b1;
                    end
                    default: last_cycle = 1'b1;
                endcase
            end
            T3: begin
                if (ir == OP_JMP_ABS) begin
                    ctl.dl_adh  = 1'b1;
                    ctl.adh_abh = 1'b1;
                    pc_load     = 1'b1;
                end
                last_cycle = 1'b1;
            end
            default: last_cycle = 1'b1;
        endcase
    end

endmodule : k6502_decode
`default_nettype wire

// File: rtl/k6502_timing.sv
`default_nettype none
// ============================================================================
// Module   : k6502_timing
// Brief    : T-state sequencer and instruction register with rdy stall gating.
// Revision : 1.0 - initial release
// ============================================================================
module k6502_timing
    import k6502_pkg::*;
(
    input  wire logic            ph0,
    input  wire logic            reset,
    k6502_timing_if.master       bus
);

    t_state_e         state_q, state_d;
    logic [7:0]       ir_q, ir_d;

    control_signals_t w_dec_ctl;
    logic             w_dec_pc_inc;
    logic             w_dec_pc_load;
    logic             w_dec_illegal;
    logic             w_dec_last;
    logic             w_run;

    k6502_decode u_decode (
        .ir         (ir_q),
        .t_state    (state_q),
        .ctl        (w_dec_ctl),
        .pc_inc     (w_dec_pc_inc),
        .pc_load    (w_dec_pc_load),
        .illegal    (w_dec_illegal),
        .last_cycle (w_dec_last)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (bus.rdy) begin
            case (state_q)
                T0: begin
                    state_d = T1;
                    ir_d    = bus.pd;
                end
                T1:      state_d = w_dec_last ? T0 : T2;
                T2:      state_d = w_dec_last ? T0 : T3;
                T3:      state_d = T0;
                default: state_d = T0;
            endcase
        end
    end

    always_ff @(posedge ph0 or posedge reset) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Reset masks everything, so no output can glitch out of an abandoned
    // instruction; a stall masks only the per-cycle actions.
    assign w_run = ~reset & bus.rdy;

    assign bus.ctl     = w_run ? w_dec_ctl : '0;
    assign bus.pc_inc  = w_run & w_dec_pc_inc;
    assign bus.pc_load = w_run & w_dec_pc_load;
    assign bus.illegal = w_run & w_dec_illegal;
    assign bus.sync    = ~reset & (state_q == T0);
    assign bus.t_state = reset ? 3'd0 : state_q;
    assign bus.ir      = reset ? 8'd0 : ir_q;

endmodule : k6502_timing
`default_nettype wire

// File: tb/tb_k6502_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_k6502_timing
// Brief    : Self-checking bench for k6502_timing against an opcode-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k6502_timing;
    import k6502_pkg::*;

    typedef struct packed {
        logic [2:0]       t_state;
        logic             sync;
        logic [7:0]       ir;
        control_signals_t ctl;
        logic             pc_inc;
        logic             pc_load;
        logic             illegal;
    } obs_t;

    logic ph0   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    logic [7:0] cur_ir = OP_NOP;
    logic watch_pc_load = 1'b0;
    logic seen_pc_load  = 1'b0;

    k6502_timing_if bus ();

    k6502_timing dut (
        .ph0   (ph0),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ph0 = ~ph0;

    always @(posedge bus.pc_load) if (watch_pc_load) seen_pc_load = 1'b1;

    // ---------------- reference model (instruction level) ----------------
    function automatic bit known(input logic [7:0] op);
        return op inside {OP_NOP, OP_TAX, OP_TAY, OP_INX, OP_INY, OP_JMP_ABS};
    endfunction

    function automatic int op_len(input logic [7:0] op);
        if (op == OP_INX || op == OP_INY) return 3;
        if (op == OP_JMP_ABS) return 4;
        return 2;
    endfunction

    function automatic control_signals_t tbl_ctl(input logic [7:0] op, input int k);
        control_signals_t c = '0;
        case (op)
            OP_TAX: if (k == 1) begin c.ac_sb = 1; c.sb_x = 1; end
            OP_TAY: if (k == 1) begin c.ac_sb = 1; c.sb_y = 1; end
            OP_INX: begin
                if (k == 1) begin c.x_sb = 1; c.sb_add = 1; end
                if (k == 2) begin c.add_sb_6_0 = 1; c.add_sb_7 = 1; c.sb_x = 1; end
            end
            OP_INY: begin
                if (k == 1) begin c.y_sb = 1; c.sb_add = 1; end
                if (k == 2) begin c.add_sb_6_0 = 1; c.add_sb_7 = 1; c.sb_y = 1; end
            end
            OP_JMP_ABS: begin
                if (k == 2) begin c.dl_adl = 1; c.adl_abl = 1; end
                if (k == 3) begin c.dl_adh = 1; c.adh_abh = 1; end
            end
            default: ;
        endcase
        return c;
    endfunction

    // k = cycle index within the instruction (0 = opcode fetch).
    function automatic obs_t model(input int k, input logic [7:0] prev_op,
                                   input logic [7:0] op, input logic r);
        obs_t o = '0;
        o.t_state = 3'(k);
        o.sync    = (k == 0);
        o.ir      = (k == 0) ? prev_op : op;
        if (r) begin
            o.ctl     = tbl_ctl(op, k);
            o.pc_inc  = (k == 0) || (op == OP_JMP_ABS && (k == 1 || k == 2));
            o.pc_load = (op == OP_JMP_ABS) && (k == 3);
            o.illegal = !known(op) && (k == 1);
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.t_state = bus.t_state;
        o.sync    = bus.sync;
        o.ir      = bus.ir;
        o.ctl     = bus.ctl;
        o.pc_inc  = bus.pc_inc;
        o.pc_load = bus.pc_load;
        o.illegal = bus.illegal;
        return o;
    endfunction

    // ------------------------------ tests ------------------------------
    task automatic test_reset();
        obs_t got;
        bus.rdy = 1'b1;
        bus.pd  = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge ph0);
            got = sample();
            checks++;
            if (got !== '0) begin
                fails++;
                $display("FAIL reset_hold_%0d: got %h expected %h", i, got, obs_t'(0));
            end
            @(posedge ph0); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_opcodes();
        logic [7:0] ops [8];
        obs_t got, exp;
        ops = '{OP_NOP, OP_TAX, OP_TAY, OP_INX, OP_INY, OP_JMP_ABS, 8'h02, 8'hFF};
        foreach (ops[n]) begin
            for (int k = 0; k < op_len(ops[n]); k++) begin
                bus.rdy = 1'b1;
                bus.pd  = (k == 0) ? ops[n] : 8'($urandom);
                @(negedge ph0);
                got = sample();
                exp = model(k, cur_ir, ops[n], 1'b1);
                checks++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL op_%h_cyc%0d: got %h expected %h", ops[n], k, got, exp);
                end
                @(posedge ph0); #1;
            end
            cur_ir  = ops[n];
            bus.rdy = 1'b0;
            bus.pd  = 8'($urandom);
            @(negedge ph0);
            got = sample();
            exp = model(0, cur_ir, 8'h00, 1'b0);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL op_%h_return_t0: got %h expected %h", ops[n], got, exp);
            end
            @(posedge ph0); #1;
        end
    endtask

    task automatic test_stall();
        logic r [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   k = 0;
        obs_t got, exp;
        for (int c = 0; c < 6; c++) begin
            bus.rdy = r[c];
            bus.pd  = (k == 0) ? OP_INX : 8'($urandom);
            @(negedge ph0);
            got = sample();
            exp = model(k, cur_ir, OP_INX, r[c]);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL stall_cyc%0d: got %h expected %h", c, got, exp);
            end
            @(posedge ph0); #1;
            if (r[c]) k++;
        end
        cur_ir  = OP_INX;
        bus.rdy = 1'b0;
        @(negedge ph0);
        got = sample();
        exp = model(0, cur_ir, 8'h00, 1'b0);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL stall_len6_return_t0: got %h expected %h", got, exp);
        end
        @(posedge ph0); #1;
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        seen_pc_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rdy = 1'b1;
            bus.pd  = (k == 0) ? OP_JMP_ABS : 8'($urandom);
            @(negedge ph0);
            got = sample();
            exp = model(k, cur_ir, OP_JMP_ABS, 1'b1);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rstmid_jmp_cyc%0d: got %h expected %h", k, got, exp);
            end
            if (k < 2) begin
                @(posedge ph0); #1;
            end
        end
        watch_pc_load = 1'b1;
        #1 reset = 1'b1;
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin
            fails++;
            $display("FAIL rstmid_immediate: got %h expected %h", got, obs_t'(0));
        end
        @(posedge ph0); #1;
        reset   = 1'b0;
        cur_ir  = OP_NOP;
        for (int k = 0; k < 3; k++) begin
            bus.rdy = (k != 0);
            bus.pd  = OP_NOP;
            @(negedge ph0);
            got = sample();
            exp = model((k == 0) ? 0 : k - 1, cur_ir, OP_NOP, bus.rdy);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rstmid_after_cyc%0d: got %h expected %h", k, got, exp);
            end
            @(posedge ph0); #1;
        end
        watch_pc_load = 1'b0;
        checks++;
        if (seen_pc_load !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_no_pc_load: got %b expected 0", seen_pc_load);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [6] = '{OP_NOP, OP_TAX, OP_TAY, OP_INX, OP_INY, OP_JMP_ABS};
        logic [7:0] op, prev;
        logic       r;
        int         k = 0;
        int         done = 0;
        obs_t       got, exp;
        prev = cur_ir;
        op   = ops[$urandom_range(5)];
        for (int c = 0; c < 2000 && done < 40; c++) begin
            r       = ($urandom_range(3) != 0);
            bus.rdy = r;
            bus.pd  = (k == 0) ? op : 8'($urandom);
            @(negedge ph0);
            got = sample();
            exp = model(k, prev, op, r);
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rand_c%0d_op_%h_k%0d: got %h expected %h", c, op, k, got, exp);
            end
            @(posedge ph0); #1;
            if (r) begin
                k++;
                if (k == op_len(op)) begin
                    k    = 0;
                    prev = op;
                    op   = ($urandom_range(6) == 6) ? 8'($urandom) : ops[$urandom_range(5)];
                    done++;
                end
            end
        end
        checks++;
        if (done != 40) begin
            fails++;
            $display("FAIL rand_budget: got %0d instructions expected 40", done);
        end
        cur_ir = prev;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.rdy = 1'b0;
        bus.pd  = 8'h00;
        test_reset();
        test_opcodes();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_k6502_timing
`default_nettype wire

// File: doc/k6502_timing.md
K6502_TIMING -- requirements
Module: k6502_timing

Interface
REQ-001 SHALL have one clock, ph0 (input, 1): core clock; all state updates occur on its rising edge.
REQ-002 SHALL have reset (input, 1): asynchronous, active-high.
REQ-003 SHALL have rdy (input, 1): 1 = advance; 0 = stall.
REQ-004 SHALL have pd (input, 8): pre-decode register contents, i.e. the opcode byte during T0.
REQ-005 SHALL have ctl (output, control_signals_t): datapath control bits, combinational from state and IR.
REQ-006 SHALL have pc_inc (output, 1): increment program counter this cycle.
REQ-007 SHALL have pc_load (output, 1): load PC from the ABH/ABL address this cycle.
REQ-008 SHALL have sync (output, 1): 1 during the opcode-fetch cycle (T0).
REQ-009 SHALL have t_state (output, 3): current T-state encoding (T0=0 … T3=3).
REQ-010 SHALL have ir (output, 8): instruction register.
REQ-011 SHALL have illegal (output, 1): 1 during T1 of an unsupported opcode.

Function
REQ-012 SHALL implement a state machine with states T0, T1, T2 and T3.
REQ-013 SHALL, in T0: assert sync=1 and pc_inc=1; on the edge with rdy=1, load ir<=pd and go to T1.
REQ-014 SHALL decode from ir only in T1..T3; pd SHALL be ignored outside T0.
REQ-015 SHALL implement the following opcode table (cycle: asserted bits; the last listed cycle returns to T0):
 - EA NOP: T1 none.
 - AA TAX: T1 ac_sb, sb_x.
 - A8 TAY: T1 ac_sb, sb_y.
 - E8 INX: T1 x_sb, sb_add; T2 add_sb_6_0, add_sb_7, sb_x.
 - C8 INY: T1 y_sb, sb_add; T2 add_sb_6_0, add_sb_7, sb_y.
 - 4C JMP abs: T1 pc_inc; T2 dl_adl, adl_abl, pc_inc; T3 dl_adh, adh_abh, pc_load.
REQ-016 SHALL treat any other opcode as a 2-cycle NOP with illegal=1 in its T1.
REQ-017 SHALL keep every ctl bit not listed for a cycle at 0.
REQ-018 SHALL, with rdy=0: hold state and ir, and force ctl, pc_inc, pc_load and illegal to 0; sync and t_state SHALL still reflect the held state.
REQ-019 SHALL, when rdy goes from 0 to 1, resume the same T-state with its normal outputs; no cycle is skipped or repeated.
REQ-020 SHALL have no state that t_state cannot encode; an unreachable encoding SHALL return to T0 on the next enabled edge.

Reset
REQ-021 SHALL, while reset=1, hold state=T0 and ir=8'hEA, and force all outputs to 0, including sync and pc_inc.
REQ-022 SHALL, on reset deassertion, begin in T0 at the first ph0 edge with sync=1.
REQ-023 SHALL, on reset asserted mid-instruction, abandon the instruction immediately (asynchronously), with no partial T-state output after reset.

Structure
REQ-024 SHALL move control_signals_t into shared package k6502_pkg, together with the opcode constants (OP_NOP, OP_TAX, OP_TAY, OP_INX, OP_INY, OP_JMP_ABS) and a T-state enum.
REQ-025 SHALL place the opcode table in one combinational sub-module, k6502_decode, with inputs ir and t_state and outputs ctl, pc_inc, pc_load, illegal and last_cycle; k6502_timing holds the state, ir and rdy gating.
REQ-026 SHALL be the sole driver of the datapath's control_signals_t in the k6502 toplevel.

Verification
REQ-027 SHALL cover reset release then pd=EA with rdy=1: sync=1, pc_inc=1 in cycle 0; T1 with all ctl=0; sync=1 again in cycle 2.
REQ-028 SHALL cover pd=E8 (INX): T1 x_sb=1, sb_add=1; T2 add_sb_6_0=1, add_sb_7=1, sb_x=1; T0 in cycle 3 with ir=8'hE8.
REQ-029 SHALL cover pd=4C (JMP abs): pc_inc in T0, T1 and T2; dl_adl+adl_abl in T2; dl_adh+adh_abh+pc_load in T3; sync in cycle 4.
REQ-030 SHALL cover pd=02 (illegal): illegal=1 only in T1; back to T0 after 2 cycles.
REQ-031 SHALL cover INX with rdy=0 for 3 cycles during T1: t_state=1 held, ctl all 0; after release x_sb, sb_add, then T2 outputs, with total length 6 cycles.
REQ-032 SHALL cover reset pulsed during JMP T2: outputs 0 immediately; after release T0 with ir=8'hEA and no pc_load ever asserted.
